dmem_access_ctrl: RTL

- Two-port arbiter and sequencer in front of the data memory (128 x 16-bit halfword array, 32-bit word = halfwords at address and address+1, registered read on posedge clk).
- Port 0 serves the pipeline MEM stage; port 1 serves a debug/DMA loader.
- Grants one requester at a time, drives the memory's address/writedata/write_en/read_en for exactly one cycle, then returns read data with a one-cycle ack.

---
 rtl/dmem_access_pkg.sv | 18 +
 rtl/rr_arb2.sv | 15 +
 rtl/dmem_access_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dmem_access_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_access_pkg;

    // Default number of 16-bit halfword locations behind the controller.
    localparam int unsigned MEM_DEPTH_DEF = 128;

    // Requester port indices.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Controller FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: on a tie, the port that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    // One-hot grant; a lone request always wins.
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & (~req_i[1] | last_grant_i);
        gnt_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port arbiter/sequencer in front of the halfword data memory.
// Port 0 is the pipeline MEM stage, port 1 the debug/DMA loader.
// Optional: define DMEM_ACCESS_BOUNDS_CHECK_EN to reject misaligned or out-of-range
// accesses with a one-cycle error ack instead of issuing them to the memory.
module dmem_access_ctrl
    import dmem_access_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    state_e            state_q;
    logic              last_grant_q;
    logic              resp_port_q;
    logic              resp_rd_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_writedata_q;
    logic              mem_write_en_q;
    logic              mem_read_en_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;

    logic [1:0]        gnt;
    logic              win_port;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              reject;

    rr_arb2 u_arb (
        .req_i        ({p1_req, p0_req}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    // Steer the winning port's command onto a common path.
    always_comb begin
        win_port  = gnt[1];
        win_we    = gnt[1] ? p1_we    : p0_we;
        win_addr  = gnt[1] ? p1_addr  : p0_addr;
        win_wdata = gnt[1] ? p1_wdata : p0_wdata;
    end

`ifdef DMEM_ACCESS_BOUNDS_CHECK_EN
    logic [ADDR_W:0] win_addr_hi;

    // Word must start on an even halfword and its second half must lie inside the array.
    always_comb begin
        win_addr_hi = {1'b0, win_addr} + {{ADDR_W{1'b0}}, 1'b1};
        reject      = win_addr[0] | (win_addr_hi >= (ADDR_W + 1)'(MEM_DEPTH));
    end
`else
    assign reject = 1'b0;
`endif

    // Sequencer FSM with all memory-side and ack outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            last_grant_q    <= PORT_DBG;
            resp_port_q     <= PORT_CPU;
            resp_rd_q       <= 1'b0;
            ack_q           <= 2'b00;
            err_q           <= 2'b00;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            mem_write_en_q  <= 1'b0;
            mem_read_en_q   <= 1'b0;
            p0_rdata_q      <= '0;
            p1_rdata_q      <= '0;
        end else begin
            // Enables and acks are single-cycle pulses unless re-armed below.
            mem_write_en_q <= 1'b0;
            mem_read_en_q  <= 1'b0;
            ack_q          <= 2'b00;
            err_q          <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        last_grant_q <= win_port;
                        resp_port_q  <= win_port;
                        if (reject) begin
                            // Rejected: skip the memory and ack with error next cycle.
                            resp_rd_q        <= 1'b0;
                            ack_q[win_port]  <= 1'b1;
                            err_q[win_port]  <= 1'b1;
                            state_q          <= StResp;
                        end else begin
                            mem_address_q   <= win_addr;
                            mem_writedata_q <= win_wdata;
                            mem_write_en_q  <= win_we;
                            mem_read_en_q   <= ~win_we;
                            resp_rd_q       <= ~win_we;
                            state_q         <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    ack_q[resp_port_q] <= 1'b1;
                    state_q            <= StResp;
                end
                StResp: begin
                    if (resp_rd_q) begin
                        if (resp_port_q == PORT_DBG) begin
                            p1_rdata_q <= mem_data;
                        end else begin
                            p0_rdata_q <= mem_data;
                        end
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign mem_write_en  = mem_write_en_q;
    assign mem_read_en   = mem_read_en_q;
    assign busy          = (state_q != StIdle);

    assign p0_ack = ack_q[0];
    assign p1_ack = ack_q[1];
    assign p0_err = err_q[0];
    assign p1_err = err_q[1];

    // Registered-read memory data is only present during RESP, so forward it while acking.
    always_comb begin
        p0_rdata = p0_rdata_q;
        p1_rdata = p1_rdata_q;
        if (state_q == StResp && resp_rd_q) begin
            if (resp_port_q == PORT_DBG) begin
                p1_rdata = mem_data;
            end else begin
                p0_rdata = mem_data;
            end
        end
    end

endmodule
